// File: rtl/spi_prot_trig_pkg.sv
// Shared LA protocol-trigger definitions: FSM states, frame widths, frame compare.
package spi_prot_trig_pkg;

    localparam int unsigned SPI_FRAME_W = 16;
    localparam int unsigned SPI_BYTE_W  = 8;
    localparam int unsigned SPI_CNT_W   = 5;

    // Bit counter saturates here so long frames never wrap back below a length.
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } spi_state_e;

    // Masked compare of the captured frame; 8-bit mode looks only at the last byte shifted in.
    function automatic logic frame_hit(
        input logic [SPI_FRAME_W-1:0] shft,
        input logic [SPI_FRAME_W-1:0] match,
        input logic [SPI_FRAME_W-1:0] mask,
        input logic [SPI_CNT_W-1:0]   bit_cnt,
        input logic                   len8
    );
        logic [SPI_FRAME_W-1:0] care;
        logic [SPI_CNT_W-1:0]   need;
        care = len8 ? {{(SPI_FRAME_W-SPI_BYTE_W){1'b0}}, ~mask[SPI_BYTE_W-1:0]} : ~mask;
        need = len8 ? SPI_CNT_W'(SPI_BYTE_W) : SPI_CNT_W'(SPI_FRAME_W);
        return (((shft ^ match) & care) == '0) && (bit_cnt >= need);
    endfunction

endpackage

// File: rtl/spi_prot_trig_sync_edge.sv
// 3-flop synchroniser with edge detect; shared by the SPI and UART trigger units.
module prot_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise_c,
    output logic fall_c
);

    logic ff1;
    logic ff2;
    logic ff3;

    // Two metastability flops, third flop delays by one for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= RST_VAL;
            ff2 <= RST_VAL;
            ff3 <= RST_VAL;
        end else begin
            ff1 <= din;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    // Delayed level lines up with the single-cycle edge pulses below.
    assign dout   = ff3;
    assign rise_c = ff2 & ~ff3;
    assign fall_c = ~ff2 & ff3;

endmodule

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: captures an SPI frame from CH1..CH3 and pulses SPItrig on a masked match.
module spi_prot_trig
    import spi_prot_trig_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   SCLK,
    input  logic                   MOSI,
    input  logic                   edg,
    input  logic                   len8,
    input  logic [SPI_FRAME_W-1:0] match,
    input  logic [SPI_FRAME_W-1:0] mask,
    output logic                   SPItrig
);

    logic ss_rise_c;
    logic ss_fall_c;
    logic sclk_rise_c;
    logic sclk_fall_c;
    logic mosi_q;
    logic smpl_c;

    spi_state_e             state;
    spi_state_e             state_nxt;
    logic [SPI_FRAME_W-1:0] shft;
    logic [SPI_FRAME_W-1:0] shft_nxt;
    logic [SPI_CNT_W-1:0]   bit_cnt;
    logic [SPI_CNT_W-1:0]   bit_cnt_nxt;
    logic                   trig_nxt;

    // Slave select idles high; only its edges are needed.
    prot_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (SS_n),
        .dout   (),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    // SPI clock idles high out of reset; only its edges are needed.
    prot_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (SCLK),
        .dout   (),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // Data uses the delayed level, aligned with the SCLK edge pulses.
    prot_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (MOSI),
        .dout   (mosi_q),
        .rise_c (),
        .fall_c ()
    );

    // Sampling edge chosen at run time.
    assign smpl_c = edg ? sclk_rise_c : sclk_fall_c;

    // State, shifter, bit counter and trigger pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shft    <= '0;
            bit_cnt <= '0;
            SPItrig <= 1'b0;
        end else begin
            state   <= state_nxt;
            shft    <= shft_nxt;
            bit_cnt <= bit_cnt_nxt;
            SPItrig <= trig_nxt;
        end
    end

    // Frame capture: SS_n fall opens a frame, SS_n rise closes it and wins over a same-cycle SCLK edge.
    always_comb begin
        state_nxt   = state;
        shft_nxt    = shft;
        bit_cnt_nxt = bit_cnt;
        trig_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_c) begin
                    state_nxt   = RX;
                    shft_nxt    = '0;
                    bit_cnt_nxt = '0;
                end
            end
            RX: begin
                if (ss_rise_c) begin
                    state_nxt = IDLE;
                    trig_nxt  = frame_hit(shft, match, mask, bit_cnt, len8);
                end else if (smpl_c) begin
                    shft_nxt    = {shft[SPI_FRAME_W-2:0], mosi_q};
                    bit_cnt_nxt = (bit_cnt == SPI_CNT_MAX) ? bit_cnt : bit_cnt + SPI_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_prot_trig.sv
// Self-checking bench for spi_prot_trig: directed table, corner sequences, randomized frames.
module tb_spi_prot_trig;
    import spi_prot_trig_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        edg;
    logic        len8;
    logic [15:0] match;
    logic [15:0] mask;
    logic        SPItrig;

    int n_checks   = 0;
    int n_pass     = 0;
    int pulses     = 0;
    int exp_pulses = 0;

    // MOSI level seen by the bench at each SCLK rise / fall of the current frame.
    bit rise_q[$];
    bit fall_q[$];

    typedef struct {
        bit          len8;
        bit          edg;
        bit          style;   // 0: data set before rise; 1: data changes 1 clk after rise
        int          nbits;
        logic [31:0] data;
        logic [15:0] match;
        logic [15:0] mask;
        bit          exp;
    } vec_t;

    vec_t vecs[15];

    spi_prot_trig dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .edg     (edg),
        .len8    (len8),
        .match   (match),
        .mask    (mask),
        .SPItrig (SPItrig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (SPItrig === 1'b1) pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference: last 8/16 sampled bits vs match under mask, with enough bits received.
    function automatic bit model_hit(input bit l8, input logic [15:0] mt, input logic [15:0] mk,
                                     input bit use_rise);
        int          n;
        int          need;
        logic [15:0] val;
        logic [15:0] care;
        n    = use_rise ? rise_q.size() : fall_q.size();
        need = l8 ? 8 : 16;
        val  = '0;
        for (int i = 0; i < need && i < n; i++)
            val[i] = use_rise ? rise_q[n-1-i] : fall_q[n-1-i];
        care = ~mk & (l8 ? 16'h00FF : 16'hFFFF);
        return (n >= need) && (((val ^ mt) & care) == 16'h0);
    endfunction

    task automatic ss_fall();
        rise_q.delete();
        fall_q.delete();
        clk_wait(1);
        SS_n = 1'b0;
        clk_wait(2);
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits, input bit style);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!style) begin
                clk_wait(1);
                MOSI = data[i];
                clk_wait(2);
                rise_q.push_back(MOSI);
                SCLK = 1'b1;
                clk_wait(2);
                fall_q.push_back(MOSI);
                SCLK = 1'b0;
            end else begin
                clk_wait(1);
                rise_q.push_back(MOSI);
                SCLK = 1'b1;
                clk_wait(1);
                MOSI = data[i];
                clk_wait(2);
                fall_q.push_back(MOSI);
                SCLK = 1'b0;
            end
        end
    endtask

    // Called right after SS_n goes high: pulse must appear on the 3rd edge only, one cycle wide.
    task automatic window_check(input bit exp, input string name);
        logic [5:0] pat;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            pat[i] = SPItrig;
        end
        check(name, 32'(pat), exp ? 32'h4 : 32'h0);
        if (exp) exp_pulses++;
    endtask

    task automatic ss_rise_check(input bit exp, input string name);
        clk_wait(2);
        SS_n = 1'b1;
        window_check(exp, name);
        check({name, "_idle"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        bit          exp;
        logic [31:0] d;
        int          nb;
        bit          st;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        edg   = 1'b1;
        len8  = 1'b1;
        match = '0;
        mask  = '0;

        vecs[0]  = '{1, 1, 0,  8, 32'h66,    16'h0066, 16'h0000, 1};
        vecs[1]  = '{1, 1, 0,  8, 32'h66,    16'h0067, 16'h0000, 0};
        vecs[2]  = '{1, 1, 0,  8, 32'h66,    16'h0067, 16'h0001, 1};
        vecs[3]  = '{0, 1, 0, 16, 32'hA5C3,  16'hA5C3, 16'h0000, 1};
        vecs[4]  = '{0, 1, 0, 12, 32'hA5C,   16'hA5C3, 16'h0000, 0};
        vecs[5]  = '{1, 0, 1,  8, 32'h66,    16'h0066, 16'h0000, 1};
        vecs[6]  = '{1, 1, 1,  8, 32'h66,    16'h0066, 16'h0000, 0};
        vecs[7]  = '{1, 1, 0,  0, 32'h0,     16'h0000, 16'hFFFF, 0};
        vecs[8]  = '{1, 1, 0, 12, 32'hF66,   16'h0066, 16'h0000, 1};
        vecs[9]  = '{0, 1, 0, 20, 32'h1A5C3, 16'hA5C3, 16'h0000, 1};
        vecs[10] = '{0, 0, 0, 16, 32'h1234,  16'h0000, 16'hFFFF, 1};
        vecs[11] = '{0, 0, 0, 15, 32'h1234,  16'h0000, 16'hFFFF, 0};
        vecs[12] = '{1, 1, 0,  7, 32'h66,    16'h0066, 16'hFFFF, 0};
        vecs[13] = '{0, 1, 0,  8, 32'hC3,    16'hA5C3, 16'hFF00, 0};
        vecs[14] = '{1, 1, 0,  8, 32'hC3,    16'hA5C3, 16'h0000, 1};

        #1;
        check("reset_trig", 32'(SPItrig), 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(4);

        // Directed vector table.
        foreach (vecs[i]) begin
            len8  = vecs[i].len8;
            edg   = vecs[i].edg;
            match = vecs[i].match;
            mask  = vecs[i].mask;
            ss_fall();
            send_bits(vecs[i].data, vecs[i].nbits, vecs[i].style);
            ss_rise_check(vecs[i].exp, $sformatf("vec%0d", i));
        end

        // SS_n glitch: low for 2 clk, no SCLK.
        len8 = 1'b1; edg = 1'b1; match = 16'h0000; mask = 16'hFFFF;
        clk_wait(1);
        SS_n = 1'b0;
        clk_wait(2);
        SS_n = 1'b1;
        window_check(1'b0, "glitch");
        check("glitch_idle", 32'(dut.state), 32'(IDLE));

        // Back-to-back frames with SS_n high for a single clk.
        mask = 16'h0000; match = 16'h0066;
        ss_fall();
        send_bits(32'h66, 8, 1'b0);
        clk_wait(2);
        SS_n = 1'b1;
        fork
            window_check(1'b1, "b2b_a");
            begin
                clk_wait(1);
                SS_n = 1'b0;
            end
        join
        send_bits(32'h66, 8, 1'b0);
        ss_rise_check(1'b1, "b2b_b");

        // Reset mid-frame after 5 bits of 0x66.
        ss_fall();
        send_bits(32'h0C, 5, 1'b0);
        clk_wait(1);
        rst_n = 1'b0;
        #1;
        check("rst_trig", 32'(SPItrig), 32'h0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_shft", 32'(dut.shft), 32'h0);
        check("rst_cnt", 32'(dut.bit_cnt), 32'h0);
        clk_wait(2);
        rst_n = 1'b1;
        send_bits(32'h6, 3, 1'b0);
        ss_rise_check(1'b0, "rst_tail");
        ss_fall();
        send_bits(32'h66, 8, 1'b0);
        ss_rise_check(1'b1, "rst_full");

        // Randomized frames against the reference model.
        for (int k = 0; k < 40; k++) begin
            len8 = 1'($urandom_range(0, 1));
            edg  = 1'($urandom_range(0, 1));
            st   = 1'($urandom_range(0, 1));
            nb   = $urandom_range(0, 20);
            d    = $urandom;
            mask = 16'($urandom & $urandom & $urandom);
            match = ($urandom_range(0, 2) != 0) ? d[15:0] : 16'($urandom);
            ss_fall();
            send_bits(d, nb, st);
            exp = model_hit(len8, match, mask, edg);
            ss_rise_check(exp, $sformatf("rnd%0d", k));
        end

        clk_wait(4);
        check("pulse_total", 32'(pulses), 32'(exp_pulses));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_prot_trig.md
Name: spi_prot_trig

Overview:
SPI protocol trigger unit inside the LA digital core, directly downstream of the CH1/CH2/CH3 channel inputs when SPI triggering is selected. It receives SS_n on CH1, SCLK on CH2 and MOSI on CH3. It captures each SPI frame and compares the frame against a host-programmed match value and don't-care mask. It emits a single-cycle SPItrig pulse that the trigger logic consumes.

Parameters:
None. Frame width is fixed at 16 bits and selected at run time by len8.

Ports:
clk  in  1  100MHz system clock
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  raw slave select from CH1 channel, asynchronous to clk
SCLK  in  1  raw SPI clock from CH2 channel, asynchronous to clk
MOSI  in  1  raw SPI data from CH3 channel, asynchronous to clk
edg  in  1  1 = sample MOSI on SCLK rise; 0 = sample on SCLK fall
len8  in  1  1 = 8-bit frame compare; 0 = 16-bit frame compare
match  in  16  compare value; only [7:0] is used when len8=1
mask  in  16  1 = don't-care bit; only [7:0] is used when len8=1
SPItrig  out  1  single-cycle pulse on a matching frame

Behaviour:
- Reset and clocking: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Synchronisers:
  - SS_n, SCLK and MOSI each pass through 2 flops, then a 3rd flop for edge detect.
  - Reset value is 1 for SS_n and SCLK, 0 for MOSI.
- Edge detection uses the 2nd and 3rd flops.
  - SCLK rise = ff2 & ~ff3; SCLK fall = ~ff2 & ff3.
  - SS_n fall and SS_n rise are detected the same way.
  - smpl = (edg ? SCLK rise : SCLK fall).
  - MOSI is taken from the 3rd flop, which aligns it with the edge pulse.
- FSM has two states, IDLE and RX. Reset state is IDLE.
  - IDLE -> RX on SS_n fall. On that transition, shft is cleared to 0 and bit_cnt to 0.
  - RX, smpl and no SS_n rise: shft <= {shft[14:0], MOSI} (MSB first). bit_cnt increments and saturates at 31.
  - RX, SS_n rise: go to IDLE and evaluate the frame. An SCLK edge in the same cycle is ignored; SS_n rise takes precedence.
  - IDLE ignores SCLK edges and SS_n rises.
- Compare, 16-bit: hit = (((shft ^ match) & ~mask) == 16'h0) & (bit_cnt >= 16).
- Compare, 8-bit: hit = (((shft[7:0] ^ match[7:0]) & ~mask[7:0]) == 8'h0) & (bit_cnt >= 8). With more than 8 bits received, the last 8 bits are compared.
- Output:
  - SPItrig is registered and reset to 0.
  - It is high for exactly 1 clk at the edge that moves RX -> IDLE with hit=1.
  - Latency: the 3rd clk edge after the raw SS_n rise is first captured.
- Boundary conditions:
  - SS_n low pulse with no SCLK edges: bit_cnt=0, no trigger.
  - Short frame (fewer bits than the selected length): no trigger.
  - Back-to-back frames with SS_n high for 1 clk are accepted. A new SS_n fall in IDLE restarts the frame.
  - rst_n asserted mid-frame: FSM goes to IDLE, shft=0, bit_cnt=0, SPItrig=0. A later SS_n rise without a preceding fall causes no trigger.
  - match, mask, edg and len8 are sampled combinationally at compare time. They must be held stable while SS_n is low.

Decomposition:
- Shared LA package holds:
  - the state enum typedef {IDLE, RX};
  - localparam SPI_FRAME_W = 16;
  - localparam SPI_BYTE_W = 8.
- One natural sub-module: prot_sync_edge. It is a 3-flop synchroniser with rise/fall outputs and a reset-value parameter. Instantiate it three times; the UART trigger unit reuses it.

Test Plan:
- 8-bit match: edg=1, len8=1, match=16'h0066, mask=0. Master sends byte 0x66 (SS_n/SCLK/MOSI muxed onto CH1-3) -> exactly one SPItrig pulse, 3 clk after SS_n rise.
- Mismatch and mask: same frame with match=16'h0067 and mask=0 -> no pulse. Repeat with mask=16'h0001 -> one pulse.
- 16-bit frame: len8=0, match=16'hA5C3, mask=0, frame 0xA5C3 -> pulse. Frame truncated to 12 bits -> no pulse, FSM returns to IDLE.
- Edge select: edg=0 with data launched on the rise and stable on the fall, frame 0x66 -> pulse. edg=1 on the same waveform where data is not stable -> shifted value, no pulse.
- SS_n glitch: SS_n low for 2 clk with no SCLK activity -> SPItrig stays 0, state is IDLE.
- Reset mid-frame: assert rst_n after 5 bits of 0x66 -> SPItrig=0 and state IDLE immediately. The following full 0x66 frame -> one pulse.
